// File: rtl/phase_wrap_counter_if.sv
//------------------------------------------------------------------------------
// phase_wrap_counter_if
//   Bundles the measurement handshake and the integrator-facing signals of
//   phase_wrap_counter. clk/rstn are kept as plain ports on the module.
//
//   start     : request a measurement (sampled only while idle)
//   align     : with start, run the integrator phase-align step first
//   win_len   : window length in clk cycles (0 behaves as 1)
//   trig      : integrator trigger, toggles once per wrap (async to clk)
//   ph_rst    : integrator reset, active high
//   busy      : measurement in progress (align, measure, report)
//   count     : wrap count of the last completed window
//   count_vld : one-cycle pulse when count/ovf update
//   ovf       : last window's count saturated
//
//   master : the side that requests measurements and supplies trig
//   slave  : the counter itself
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface phase_wrap_counter_if #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned WIN_W = 16
);
   logic             start;
   logic             align;
   logic [WIN_W-1:0] win_len;
   logic             trig;
   logic             ph_rst;
   logic             busy;
   logic [CNT_W-1:0] count;
   logic             count_vld;
   logic             ovf;

   modport master (
      output start, align, win_len, trig,
      input  ph_rst, busy, count, count_vld, ovf
   );

   modport slave (
      input  start, align, win_len, trig,
      output ph_rst, busy, count, count_vld, ovf
   );
endinterface

// File: rtl/phase_wrap_counter.sv
//------------------------------------------------------------------------------
// phase_wrap_counter
//   Frequency-measurement front end for the phase-domain PWL oscillator model.
//   Counts integrator wraps (trigger toggles) over a programmable window of
//   reference-clock cycles, optionally pulsing the integrator reset first to
//   phase-align it.
//
//   Ports:
//     clk  : reference clock, all state changes on posedge
//     rstn : asynchronous active-low reset
//     bus  : phase_wrap_counter_if.slave (start/align/win_len/trig in,
//            ph_rst/busy/count/count_vld/ovf out)
//
//   Timing: start accepted at edge k -> optional ALIGN for RST_CYC cycles,
//   then MEAS for the latched window, then one DONE cycle carrying count_vld.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module phase_wrap_counter #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned WIN_W       = 16,
   parameter int unsigned RST_CYC     = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic                clk,
   input logic                rstn,
   phase_wrap_counter_if.slave bus
);

   localparam int unsigned RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

   typedef enum logic [1:0] {IDLE, ALIGN, MEAS, DONE} state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   tp_q;
   logic                   ts;
   logic                   evt;
   logic [WIN_W-1:0]       win_q;
   logic [RC_W-1:0]        rcnt_q;
   logic [CNT_W-1:0]       evt_q, evt_d;
   logic                   ovf_flag_q, ovf_flag_d;
   logic [CNT_W-1:0]       count_q;
   logic                   ovf_q;
   logic                   vld_q;
   logic                   ph_rst_q;
   logic                   busy_q;

   // tp follows ts in every state, so entering MEAS never manufactures an edge.
   assign ts  = sync_q[SYNC_STAGES-1];
   assign evt = ts ^ tp_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= '0;
         tp_q   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.trig};
         tp_q   <= ts;
      end
   end

   // Saturating event counter; the sticky flag records a wrap lost at full scale.
   always_comb begin
      evt_d      = evt_q;
      ovf_flag_d = ovf_flag_q;
      if (state_q == MEAS && evt) begin
         if (evt_q == '1) ovf_flag_d = 1'b1;
         else             evt_d      = evt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         win_q      <= '0;
         rcnt_q     <= '0;
         evt_q      <= '0;
         ovf_flag_q <= 1'b0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         vld_q      <= 1'b0;
         ph_rst_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         vld_q      <= 1'b0;
         evt_q      <= evt_d;
         ovf_flag_q <= ovf_flag_d;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  win_q      <= (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
                  evt_q      <= '0;
                  ovf_flag_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (bus.align) begin
                     state_q  <= ALIGN;
                     ph_rst_q <= 1'b1;
                     rcnt_q   <= RC_W'(RST_CYC - 1);
                  end else begin
                     state_q  <= MEAS;
                  end
               end
            end
            ALIGN: begin
               if (rcnt_q == '0) begin
                  ph_rst_q <= 1'b0;
                  state_q  <= MEAS;
               end else begin
                  rcnt_q   <= rcnt_q - RC_W'(1);
               end
            end
            MEAS: begin
               // Report uses the next-state count so an event on the last
               // window cycle is included.
               if (win_q == WIN_W'(1)) begin
                  state_q <= DONE;
                  count_q <= evt_d;
                  ovf_q   <= ovf_flag_d;
                  vld_q   <= 1'b1;
               end else begin
                  win_q   <= win_q - WIN_W'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ph_rst    = ph_rst_q;
   assign bus.busy      = busy_q;
   assign bus.count     = count_q;
   assign bus.count_vld = vld_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_phase_wrap_counter.sv
`timescale 1ns/1ps
module tb_phase_wrap_counter;

   localparam int RST   = 2;
   localparam int SYNC  = 2;
   localparam int CMAXA = 65535;
   localparam int HMAX  = 8192;

   logic clk  = 1'b1;
   logic rstn = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   int per_a    = 30;
   bit static_a = 1'b0;

   phase_wrap_counter_if #(.CNT_W(16), .WIN_W(16)) ifa ();
   phase_wrap_counter_if #(.CNT_W(4),  .WIN_W(16)) ifb ();

   phase_wrap_counter #(.CNT_W(16), .WIN_W(16), .RST_CYC(RST), .SYNC_STAGES(SYNC)) dut_a (
      .clk(clk), .rstn(rstn), .bus(ifa));
   phase_wrap_counter #(.CNT_W(4), .WIN_W(16), .RST_CYC(RST), .SYNC_STAGES(SYNC)) dut_b (
      .clk(clk), .rstn(rstn), .bus(ifb));

   // posedges at 10,20,...; trig edges always land on negedges (5 mod 10)
   initial forever #5 clk = ~clk;

   initial begin
      ifa.trig = 1'b0;
      #5;
      forever begin
         if (per_a == 0) begin
            ifa.trig = static_a;
            #10;
         end else begin
            ifa.trig = ~ifa.trig;
            #(per_a);
         end
      end
   end

   initial begin
      ifb.trig = 1'b0;
      #5;
      forever begin
         ifb.trig = ~ifb.trig;
         #20;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   //---------------------------------------------------------------------------
   // Model of DUT A: per-edge history of sampled trig; a wrap is visible
   // SYNC edges after it is sampled. Transactions are described by the
   // accepting edge k: ALIGN covers edges k..k+A-1, MEAS k+A..k+A+W-1,
   // DONE at k+A+W.
   //---------------------------------------------------------------------------
   bit hist [0:HMAX-1];
   int ecyc = 0;
   int zero_upto = 0;
   bit m_active = 1'b0;
   int m_k, m_A, m_W, m_evt;
   bit m_sat;
   bit e_busy = 1'b0, e_ph = 1'b0, e_vld = 1'b0, e_ovf = 1'b0;
   int e_cnt = 0;

   function automatic bit samp(int i);
      if (i <= zero_upto) return 1'b0;
      return hist[i % HMAX];
   endfunction

   function automatic bit ev(int e);
      return samp(e - SYNC + 1) != samp(e - SYNC);
   endfunction

   initial begin
      bit was_idle;
      int rel;
      forever begin
         @(posedge clk or negedge rstn);
         ecyc = ecyc + 1;
         if (!rstn) begin
            zero_upto = ecyc;
            hist[ecyc % HMAX] = 1'b0;
            m_active = 1'b0;
            e_busy = 1'b0; e_ph = 1'b0; e_vld = 1'b0; e_ovf = 1'b0; e_cnt = 0;
         end else begin
            hist[ecyc % HMAX] = ifa.trig;
            was_idle = !m_active;
            if (m_active && (ecyc - m_k) > (m_A + m_W)) m_active = 1'b0;
            if (was_idle && ifa.start) begin
               m_active = 1'b1;
               m_k   = ecyc;
               m_A   = ifa.align ? RST : 0;
               m_W   = (ifa.win_len == 16'd0) ? 1 : int'(ifa.win_len);
               m_evt = 0;
               m_sat = 1'b0;
            end
            e_ph   = 1'b0;
            e_vld  = 1'b0;
            e_busy = m_active;
            if (m_active) begin
               rel = ecyc - m_k;
               if (rel < m_A) e_ph = 1'b1;
               if (rel >= m_A && rel < m_A + m_W && ev(ecyc)) begin
                  if (m_evt == CMAXA) m_sat = 1'b1;
                  else                m_evt = m_evt + 1;
               end
               if (rel == m_A + m_W) begin
                  e_vld = 1'b1;
                  e_cnt = m_evt;
                  e_ovf = m_sat;
               end
            end
         end
      end
   end

   function automatic void chk(string nm, int act, int exp);
      n_tests = n_tests + 1;
      if (act != exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic run_a(input int w, input bit al, input int ec, input bit eo,
                        input int elat, input int eph, input string nm);
      int lat;
      int phc;
      @(negedge clk);
      ifa.start = 1'b1; ifa.align = al; ifa.win_len = 16'(w);
      @(negedge clk);
      ifa.start = 1'b0; ifa.align = 1'b0;
      lat = -1;
      phc = 0;
      for (int i = 0; i < 400; i++) begin
         if (i > 0) @(negedge clk);
         if (ifa.ph_rst) phc++;
         if (ifa.count_vld) begin
            lat = i + 1;
            break;
         end
      end
      chk({nm, "_latency"}, lat, elat);
      chk({nm, "_count"}, int'(ifa.count), ec);
      chk({nm, "_ovf"}, int'(ifa.ovf), int'(eo));
      chk({nm, "_ph_rst_cycles"}, phc, eph);
      @(negedge clk);
      chk({nm, "_vld_single"}, int'(ifa.count_vld), 0);
      chk({nm, "_busy_drop"}, int'(ifa.busy), 0);
   endtask

   task automatic run_b(input int w, input int ec, input bit eo, input int elat,
                        input string nm);
      int lat;
      @(negedge clk);
      ifb.start = 1'b1; ifb.align = 1'b0; ifb.win_len = 16'(w);
      @(negedge clk);
      ifb.start = 1'b0;
      lat = -1;
      for (int i = 0; i < 400; i++) begin
         if (i > 0) @(negedge clk);
         if (ifb.count_vld) begin
            lat = i + 1;
            break;
         end
      end
      chk({nm, "_latency"}, lat, elat);
      chk({nm, "_count"}, int'(ifb.count), ec);
      chk({nm, "_ovf"}, int'(ifb.ovf), int'(eo));
      @(negedge clk);
      chk({nm, "_vld_single"}, int'(ifb.count_vld), 0);
   endtask

   initial begin
      int lat;
      int vcnt;
      ifa.start = 1'b0; ifa.align = 1'b0; ifa.win_len = '0;
      ifb.start = 1'b0; ifb.align = 1'b0; ifb.win_len = '0;

      fork
         forever begin
            @(negedge clk);
            chk("m_busy",      int'(ifa.busy),      int'(e_busy));
            chk("m_ph_rst",    int'(ifa.ph_rst),    int'(e_ph));
            chk("m_count_vld", int'(ifa.count_vld), int'(e_vld));
            chk("m_count",     int'(ifa.count),     e_cnt);
            chk("m_ovf",       int'(ifa.ovf),       int'(e_ovf));
         end
      join_none

      #1 rstn = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy",   int'(ifa.busy),      0);
      chk("rst_count",  int'(ifa.count),     0);
      chk("rst_vld",    int'(ifa.count_vld), 0);
      chk("rst_ph_rst", int'(ifa.ph_rst),    0);
      chk("rst_ovf",    int'(ifa.ovf),       0);
      @(posedge clk); #2 rstn = 1'b1;
      repeat (3) @(negedge clk);

      run_a(99, 1'b0, 33, 1'b0, 100, 0, "meas99");
      run_a(99, 1'b1, 33, 1'b0, 102, 2, "align99");

      run_b(64, 15, 1'b1, 65, "sat64");
      run_b(10, 5, 1'b0, 11, "win10");

      // start re-pulsed in MEAS (with a different length) and in DONE
      @(negedge clk);
      ifa.start = 1'b1; ifa.win_len = 16'd30;
      @(negedge clk);
      ifa.start = 1'b0;
      lat = -1;
      for (int n = 0; n < 200; n++) begin
         if (n > 0) @(negedge clk);
         if (n == 5) begin ifa.start = 1'b1; ifa.win_len = 16'd5; end
         if (n == 6) ifa.start = 1'b0;
         if (ifa.count_vld) begin
            lat = n + 1;
            ifa.start = 1'b1;
            break;
         end
      end
      chk("ign_latency", lat, 31);
      chk("ign_count", int'(ifa.count), 10);
      @(negedge clk);
      ifa.start = 1'b0;
      vcnt = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (ifa.count_vld) vcnt++;
      end
      chk("ign_extra_vld", vcnt, 0);

      // zero-length window behaves as one cycle; static trig gives no events
      per_a = 0; static_a = 1'b0;
      repeat (6) @(negedge clk);
      run_a(0, 1'b0, 0, 1'b0, 2, 0, "win0");

      // trig held high through reset release, then a measurement
      static_a = 1'b1;
      repeat (4) @(negedge clk);
      @(posedge clk); #2 rstn = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #2 rstn = 1'b1;
      repeat (5) @(negedge clk);
      run_a(10, 1'b0, 0, 1'b0, 11, 0, "static1");

      // reset mid-measurement after a non-zero count has been reported
      per_a = 30;
      repeat (4) @(negedge clk);
      run_a(99, 1'b0, 33, 1'b0, 100, 0, "pre_abort");
      @(negedge clk);
      ifa.start = 1'b1; ifa.win_len = 16'd99;
      @(negedge clk);
      ifa.start = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_busy_before", int'(ifa.busy), 1);
      @(posedge clk); #2 rstn = 1'b0;
      #1;
      chk("abort_busy",   int'(ifa.busy),      0);
      chk("abort_count",  int'(ifa.count),     0);
      chk("abort_vld",    int'(ifa.count_vld), 0);
      chk("abort_ph_rst", int'(ifa.ph_rst),    0);
      chk("abort_ovf",    int'(ifa.ovf),       0);
      repeat (2) @(negedge clk);
      @(posedge clk); #2 rstn = 1'b1;
      repeat (3) @(negedge clk);
      run_a(99, 1'b0, 33, 1'b0, 100, 0, "post_abort");

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
